// File: rtl/pkt_tx_pkg.sv
// Shared types and constants for the packet transmit framer and its frame buffer.
package pkt_tx_pkg;

    localparam int unsigned ETH_MIN_BYTES = 60;
    localparam int unsigned PKT_DATA_W    = 32;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        PAD,
        GAP
    } tx_state_t;

    typedef struct packed {
        logic                  tlast;
        logic [PKT_DATA_W-1:0] data;
    } buf_word_t;

endpackage

// File: rtl/pkt_tx_buffer.sv
// Circular frame buffer with commit/rewind on the write side, a registered read port that never
// passes the committed write pointer, and a count of committed frames awaiting transmit.
module pkt_tx_buffer #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 512,
    parameter int unsigned AVAIL_W    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en_i,
    input  logic [DATA_W-1:0]  wr_data_i,
    input  logic               wr_last_i,
    input  logic               wr_permit_i,
    input  logic               rd_en_i,
    output logic [DATA_W-1:0]  rd_data_o,
    output logic               rd_last_o,
    input  logic               tx_done_i,
    output logic [AVAIL_W-1:0] frames_avail_o,
    output logic               drop_o
);
    localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);

    // Entry layout matches buf_word_t: tlast in the MSB above the data word.
    logic [DATA_W:0]     mem [FIFO_DEPTH];
    logic [DATA_W:0]     rd_word_q;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d, rd_ptr_q, wr_ptr_inc;
    logic [AVAIL_W-1:0]  avail_q;
    logic                ovf_q, ovf_d, full, commit, rd_ok;

    assign wr_ptr_inc = wr_ptr_q + ADDR_W'(1);
    assign full       = (wr_ptr_inc == rd_ptr_q);
    assign rd_ok      = rd_en_i && (rd_ptr_q != wr_commit_q);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        ovf_d       = ovf_q;
        commit      = 1'b0;
        drop_o      = 1'b0;
        if (wr_en_i) begin
            if (wr_last_i) begin
                // A full tlast beat is itself lost, so the frame counts as overflowed.
                if (wr_permit_i && !ovf_q && !full) begin
                    wr_ptr_d    = wr_ptr_inc;
                    wr_commit_d = wr_ptr_inc;
                    commit      = 1'b1;
                end else begin
                    wr_ptr_d = wr_commit_q;
                    ovf_d    = 1'b0;
                    drop_o   = 1'b1;
                end
            end else if (full) begin
                ovf_d = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i && !full) begin
            mem[wr_ptr_q] <= {wr_last_i, wr_data_i};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            ovf_q       <= 1'b0;
            avail_q     <= '0;
            rd_word_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            ovf_q       <= ovf_d;
            if (rd_ok) begin
                rd_word_q <= mem[rd_ptr_q];
                rd_ptr_q  <= rd_ptr_q + ADDR_W'(1);
            end
            case ({commit, tx_done_i})
                2'b10:   avail_q <= avail_q + AVAIL_W'(1);
                2'b01:   avail_q <= avail_q - AVAIL_W'(1);
                default: ;
            endcase
        end
    end

    assign rd_data_o      = rd_word_q[DATA_W-1:0];
    assign rd_last_o      = rd_word_q[DATA_W];
    assign frames_avail_o = avail_q;

endmodule

// File: rtl/packet_tx_framer.sv
// Store-and-forward transmit framer: streams ACL-permitted frames to the MAC with minimum-length
// zero padding and an inter-frame gap. Define PKT_TX_STATS_EN to build the frame counters.
module packet_tx_framer
    import pkt_tx_pkg::*;
#(
    parameter int unsigned C_m_axis_txd_TDATA_WIDTH = PKT_DATA_W,
    parameter int unsigned FIFO_DEPTH               = 512,
    parameter int unsigned MIN_FRAME_WORDS          = ETH_MIN_BYTES / (PKT_DATA_W / 8),
    parameter int unsigned IFG_CYCLES               = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [C_m_axis_txd_TDATA_WIDTH-1:0] i_pkt_tdata,
    input  logic                                i_pkt_tvalid,
    input  logic                                i_pkt_tlast,
    input  logic                                i_pkt_permit,
    output logic                                o_pkt_tready,
    output logic [C_m_axis_txd_TDATA_WIDTH-1:0] o_txd_tdata,
    output logic                                o_txd_tvalid,
    output logic                                o_txd_tlast,
    input  logic                                i_txd_tready,
    output logic [15:0]                         o_frames_sent,
    output logic [15:0]                         o_frames_dropped
);
    localparam int unsigned W       = C_m_axis_txd_TDATA_WIDTH;
    localparam int unsigned AVAIL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CNT_W   = 16;
    localparam logic [CNT_W-1:0] MIN_W = CNT_W'(MIN_FRAME_WORDS);
    localparam logic [CNT_W-1:0] IFG_W = CNT_W'(IFG_CYCLES);

    tx_state_t          state_q;
    logic [CNT_W-1:0]   cnt_q, gap_q;
    logic [W-1:0]       tdata_q, rd_data;
    logic               tvalid_q, tlast_q, ready_q;
    logic               wr_en, rd_en, rd_last, tx_done, drop, load, cnt_done;
    logic [AVAIL_W-1:0] frames_avail;

    assign wr_en    = i_pkt_tvalid && ready_q;
    assign load     = !tvalid_q || i_txd_tready;
    assign cnt_done = (cnt_q + CNT_W'(1)) >= MIN_W;

    pkt_tx_buffer #(
        .DATA_W    (W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .AVAIL_W   (AVAIL_W)
    ) u_buffer (
        .clk           (clk),
        .rst           (rst),
        .wr_en_i       (wr_en),
        .wr_data_i     (i_pkt_tdata),
        .wr_last_i     (i_pkt_tlast),
        .wr_permit_i   (i_pkt_permit),
        .rd_en_i       (rd_en),
        .rd_data_o     (rd_data),
        .rd_last_o     (rd_last),
        .tx_done_i     (tx_done),
        .frames_avail_o(frames_avail),
        .drop_o        (drop)
    );

    // The read port is one word ahead of the output register: prefetch on entry to SEND and
    // after every consumed word except the stored tlast.
    always_comb begin
        rd_en   = 1'b0;
        tx_done = 1'b0;
        case (state_q)
            IDLE:    rd_en = (frames_avail != '0);
            SEND: begin
                rd_en   = load && !rd_last;
                tx_done = load && rd_last && cnt_done;
            end
            PAD:     tx_done = load && cnt_done;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            gap_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (frames_avail != '0) begin
                        state_q <= SEND;
                        cnt_q   <= '0;
                    end
                end
                SEND: begin
                    if (load) begin
                        tdata_q  <= rd_data;
                        tvalid_q <= 1'b1;
                        cnt_q    <= cnt_q + CNT_W'(1);
                        tlast_q  <= rd_last && cnt_done;
                        if (rd_last) begin
                            state_q <= cnt_done ? GAP : PAD;
                        end
                    end
                end
                PAD: begin
                    if (load) begin
                        tdata_q  <= '0;
                        tvalid_q <= 1'b1;
                        cnt_q    <= cnt_q + CNT_W'(1);
                        tlast_q  <= cnt_done;
                        if (cnt_done) begin
                            state_q <= GAP;
                        end
                    end
                end
                GAP: begin
                    // Hold the tlast beat until accepted, then count idle cycles.
                    if (tvalid_q) begin
                        if (i_txd_tready) begin
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            gap_q    <= '0;
                        end
                    end else if ((gap_q + CNT_W'(1)) >= IFG_W) begin
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_pkt_tready = ready_q;
    assign o_txd_tdata  = tdata_q;
    assign o_txd_tvalid = tvalid_q;
    assign o_txd_tlast  = tlast_q;

`ifdef PKT_TX_STATS_EN
    logic [15:0] sent_q, dropped_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sent_q    <= '0;
            dropped_q <= '0;
        end else begin
            if (tx_done && (sent_q != 16'hFFFF)) begin
                sent_q <= sent_q + 16'd1;
            end
            if (drop && (dropped_q != 16'hFFFF)) begin
                dropped_q <= dropped_q + 16'd1;
            end
        end
    end

    assign o_frames_sent    = sent_q;
    assign o_frames_dropped = dropped_q;
`else
    logic unused_drop;
    assign unused_drop      = drop;
    assign o_frames_sent    = 16'h0000;
    assign o_frames_dropped = 16'h0000;
`endif

endmodule

// File: tb/tb_packet_tx_framer.sv
// Randomized bench for packet_tx_framer against a frame-level reference model; a second,
// shallow instance exercises buffer overflow.
`timescale 1ns/1ps
module tb_packet_tx_framer;

    localparam int unsigned MIN = 15;
    localparam int unsigned IFG = 3;
`ifdef PKT_TX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] i_pkt_tdata = '0;
    logic        i_pkt_tvalid = 1'b0, i_pkt_tlast = 1'b0, i_pkt_permit = 1'b0;
    logic        i_txd_tready = 1'b1, s_txd_tready = 1'b1;
    logic        o_pkt_tready, s_pkt_tready;
    logic [31:0] o_txd_tdata, s_txd_tdata;
    logic        o_txd_tvalid, o_txd_tlast, s_txd_tvalid, s_txd_tlast;
    logic [15:0] o_frames_sent, o_frames_dropped, s_frames_sent, s_frames_dropped;

    always #5 clk = ~clk;

    packet_tx_framer dut (
        .clk(clk), .rst(rst),
        .i_pkt_tdata(i_pkt_tdata), .i_pkt_tvalid(i_pkt_tvalid), .i_pkt_tlast(i_pkt_tlast),
        .i_pkt_permit(i_pkt_permit), .o_pkt_tready(o_pkt_tready),
        .o_txd_tdata(o_txd_tdata), .o_txd_tvalid(o_txd_tvalid), .o_txd_tlast(o_txd_tlast),
        .i_txd_tready(i_txd_tready),
        .o_frames_sent(o_frames_sent), .o_frames_dropped(o_frames_dropped)
    );

    packet_tx_framer #(.FIFO_DEPTH(16)) dut_small (
        .clk(clk), .rst(rst),
        .i_pkt_tdata(i_pkt_tdata), .i_pkt_tvalid(i_pkt_tvalid), .i_pkt_tlast(i_pkt_tlast),
        .i_pkt_permit(i_pkt_permit), .o_pkt_tready(s_pkt_tready),
        .o_txd_tdata(s_txd_tdata), .o_txd_tvalid(s_txd_tvalid), .o_txd_tlast(s_txd_tlast),
        .i_txd_tready(s_txd_tready),
        .o_frames_sent(s_frames_sent), .o_frames_dropped(s_frames_dropped)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: a permitted frame becomes its words zero-padded to MIN, tlast on the final.
    logic [31:0] fw[$];
    logic [32:0] exp_q[$];
    int          exp_sent = 0, exp_dropped = 0;

    function automatic logic [15:0] stat(input int n);
        return STATS ? 16'(n) : 16'h0000;
    endfunction

    function automatic void model_frame(input logic permit);
        int n;
        int tot;
        n   = fw.size();
        tot = (n < MIN) ? MIN : n;
        if (!permit) begin
            exp_dropped++;
            return;
        end
        for (int i = 0; i < tot; i++) begin
            exp_q.push_back({i == tot - 1, (i < n) ? fw[i] : 32'h0});
        end
        exp_sent++;
    endfunction

    // 0: always ready, 1: toggle, 2: random, other: stalled
    int tr_mode = 0;
    always @(posedge clk) begin
        #1;
        case (tr_mode)
            0:       i_txd_tready = 1'b1;
            1:       i_txd_tready = ~i_txd_tready;
            2:       i_txd_tready = ($urandom_range(0, 3) != 0);
            default: i_txd_tready = 1'b0;
        endcase
    end

    int          hs_cnt = 0;
    bit          stall_prev = 0, in_gap = 0;
    int          low_cnt = 0;
    logic [32:0] stall_word, w;
    logic [32:0] s_got[$];

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            s_got.delete();
            stall_prev = 0;
            in_gap     = 0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", o_txd_tvalid, 1);
                check("stall_word", {o_txd_tlast, o_txd_tdata}, stall_word);
            end
            if (in_gap) begin
                if (o_txd_tvalid) begin
                    check("ifg_min", low_cnt >= IFG, 1);
                    in_gap = 0;
                end else begin
                    low_cnt++;
                end
            end
            if (o_txd_tvalid && i_txd_tready) begin
                hs_cnt++;
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    check("txd_data", o_txd_tdata, w[31:0]);
                    check("txd_last", o_txd_tlast, w[32]);
                end
                if (o_txd_tlast) begin
                    in_gap  = 1;
                    low_cnt = 0;
                end
            end
            stall_prev = o_txd_tvalid && !i_txd_tready;
            stall_word = {o_txd_tlast, o_txd_tdata};
            if (s_txd_tvalid && s_txd_tready) s_got.push_back({s_txd_tlast, s_txd_tdata});
        end
    end

    task automatic send_frame(input logic permit, input bit gaps);
        int guard;
        guard = 0;
        while (!o_pkt_tready && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        for (int i = 0; i < fw.size(); i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    i_pkt_tvalid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            i_pkt_tvalid = 1'b1;
            i_pkt_tdata  = fw[i];
            i_pkt_tlast  = (i == fw.size() - 1);
            i_pkt_permit = i_pkt_tlast ? permit : 1'($urandom);
            @(posedge clk); #1;
        end
        i_pkt_tvalid = 1'b0;
        i_pkt_tlast  = 1'b0;
        i_pkt_permit = 1'b0;
        model_frame(permit);
    endtask

    task automatic rand_frame(input int len);
        fw.delete();
        for (int i = 0; i < len; i++) fw.push_back($urandom);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || o_txd_tvalid) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("%s_drain", tag), exp_q.size(), 0);
        repeat (IFG + 3) @(posedge clk);
        #1;
        check($sformatf("%s_sent", tag), o_frames_sent, stat(exp_sent));
        check($sformatf("%s_dropped", tag), o_frames_dropped, stat(exp_dropped));
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check($sformatf("%s_rst_out", tag),
              {o_txd_tdata, o_txd_tvalid, o_txd_tlast, o_pkt_tready}, 0);
        check($sformatf("%s_rst_cnt", tag), {o_frames_sent, o_frames_dropped}, 0);
        exp_sent    = 0;
        exp_dropped = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check($sformatf("%s_rdy_rel", tag), o_pkt_tready, 0);
        @(posedge clk); #1;
        check($sformatf("%s_rdy_on", tag), o_pkt_tready, 1);
    endtask

    logic [31:0] f1[$];
    int          base, n;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_main", {o_txd_tdata, o_txd_tvalid, o_txd_tlast, o_pkt_tready}, 0);
        check("reset_cnt", {o_frames_sent, o_frames_dropped}, 0);
        check("reset_small", {s_txd_tvalid, s_pkt_tready}, 0);
        do_reset("init");

        // 20-word frame, checking the two-cycle presentation latency
        fw.delete();
        for (int i = 1; i <= 20; i++) fw.push_back(32'(i));
        send_frame(1'b1, 1'b0);
        @(posedge clk); #1;
        check("lat_p1_valid", o_txd_tvalid, 0);
        @(posedge clk); #1;
        check("lat_p2_valid", o_txd_tvalid, 1);
        check("lat_p2_data", o_txd_tdata, 32'h1);
        wait_drain("t20");

        rand_frame(5);
        send_frame(1'b1, 1'b0);
        wait_drain("pad5");

        rand_frame(20);
        send_frame(1'b0, 1'b0);
        rand_frame(16);
        send_frame(1'b1, 1'b0);
        wait_drain("deny");

        tr_mode = 1;
        rand_frame(16);
        send_frame(1'b1, 1'b1);
        wait_drain("toggle");
        tr_mode = 0;

        // Overflow in the 16-deep instance while its MAC is stalled
        do_reset("ovf");
        s_txd_tready = 1'b0;
        tr_mode      = 2;
        rand_frame(10);
        f1 = fw;
        send_frame(1'b1, 1'b0);
        rand_frame(10);
        send_frame(1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("ovf_dropped", s_frames_dropped, stat(1));
        s_txd_tready = 1'b1;
        n = 0;
        while (s_got.size() < MIN && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (40) @(posedge clk);
        #1;
        check("ovf_beats", s_got.size(), MIN);
        for (int i = 0; i < MIN && i < s_got.size(); i++) begin
            check($sformatf("ovf_word%0d", i), s_got[i],
                  {i == MIN - 1, (i < 10) ? f1[i] : 32'h0});
        end
        check("ovf_sent", s_frames_sent, stat(1));
        check("ovf_dropped_end", s_frames_dropped, stat(1));
        wait_drain("ovf_main");
        tr_mode = 0;

        // Reset in the middle of a transmission
        rand_frame(20);
        base = hs_cnt;
        send_frame(1'b1, 1'b0);
        n = 0;
        while (hs_cnt < base + 7 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("midtx_reached", hs_cnt >= base + 7, 1);
        do_reset("midtx");
        repeat (5) @(posedge clk);
        #1;
        check("midtx_idle", o_txd_tvalid, 0);
        rand_frame(12);
        send_frame(1'b1, 1'b0);
        wait_drain("after_rst");

        // Random frames, verdicts, input gaps and MAC backpressure
        tr_mode = 2;
        for (int f = 0; f < 20; f++) begin
            rand_frame($urandom_range(1, 24));
            send_frame($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0);
        end
        wait_drain("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/packet_tx_framer.md
Name: packet_tx_framer

Overview:
- Transmit-side counterpart of packet_parser: a store-and-forward framer between the ACL verdict stage and the MAC transmit AXI-Stream (txd) interface.
- Buffers each incoming frame in a circular word buffer and waits for the ACL verdict on the frame's last beat.
- Permitted frames are committed and streamed out with minimum-length zero padding and an inter-frame gap.
- Denied or overflowed frames are discarded by rewinding the write pointer.

Parameters:
- C_m_axis_txd_TDATA_WIDTH, 32, data width of the input and txd streams.
- FIFO_DEPTH, 512, buffer depth in words (power of 2); address width = $clog2(FIFO_DEPTH).
- MIN_FRAME_WORDS, 15, minimum transmitted frame length in words (60 bytes at 32 bits).
- IFG_CYCLES, 3, idle cycles forced after each transmitted tlast.

Ports:
- clk  in  1  system clock (156.25 MHz).
- rst  in  1  reset; one clock, asynchronous and active-high.
- i_pkt_tdata  in  C_m_axis_txd_TDATA_WIDTH  frame word from the ACL stage.
- i_pkt_tvalid  in  1  input beat valid.
- i_pkt_tlast  in  1  last beat of the frame.
- i_pkt_permit  in  1  ACL verdict, sampled only on an accepted tlast beat (1 = forward).
- o_pkt_tready  out  1  input ready.
- o_txd_tdata  out  C_m_axis_txd_TDATA_WIDTH  transmit word.
- o_txd_tvalid  out  1  transmit beat valid.
- o_txd_tlast  out  1  last transmit beat.
- i_txd_tready  in  1  MAC ready.
- o_frames_sent  out  16  count of transmitted frames.
- o_frames_dropped  out  16  count of dropped frames (denied or overflowed).

Behaviour:
- Reset values: all outputs 0; wr_ptr, wr_commit, rd_ptr, frames_avail and counters 0; FSM in IDLE.
- o_pkt_tready is registered. It is 0 during reset and in the first clk after release, then held at 1. The writer never backpressures.
- Write side:
  - Each accepted beat (tvalid & tready) stores {tlast, tdata} at wr_ptr; wr_ptr increments modulo FIFO_DEPTH.
  - Full is defined as wr_ptr+1 == rd_ptr.
  - A beat arriving while full is discarded and sets the frame's overflow flag.
- At an accepted tlast beat (the tlast word itself is stored unless full):
  - If permit=1 and the overflow flag is clear: wr_commit <= new wr_ptr and frames_avail increments.
  - Otherwise: wr_ptr <= wr_commit, o_frames_dropped increments and the overflow flag clears.
- The first beat after reset release starts a new frame, even if the source was mid-frame.
- Read side never reads past wr_commit.
- If a commit and a tx frame completion occur in the same cycle, frames_avail is unchanged.
- TX FSM:
  - IDLE: if frames_avail != 0, go to SEND. The first word is presented 2 cycles after the committing tlast beat.
  - SEND: output registers load a buffered word when !o_txd_tvalid || i_txd_tready.
    - tdata/tvalid/tlast stay stable while tvalid & !tready.
    - A word counter counts handshakes.
    - When the stored tlast word is sent and count+1 >= MIN_FRAME_WORDS: assert o_txd_tlast on that word, decrement frames_avail, increment o_frames_sent, go to GAP.
    - Otherwise suppress tlast and go to PAD.
  - PAD: emit zero words until the word count reaches MIN_FRAME_WORDS; tlast is asserted on the final pad word; then go to GAP.
  - GAP: o_txd_tvalid=0 for IFG_CYCLES cycles, then go to IDLE.
- Counters are 16-bit and saturate at 16'hFFFF.
- Reset mid-transmission clears everything immediately; any partial frame on txd is abandoned without tlast.

Optional Feature:
- Macro: PKT_TX_STATS_EN.
- Defined: o_frames_sent and o_frames_dropped are saturating counters as described.
- Undefined: counter logic is not instantiated and both ports are tied to 16'h0000. The datapath is unchanged.

Decomposition:
- Shared package pkt_tx_pkg holds:
  - typedef tx_state_t {IDLE, SEND, PAD, GAP};
  - typedef buf_word_t (1-bit tlast plus data);
  - localparam ETH_MIN_BYTES = 60.
- One natural sub-module, pkt_tx_buffer: the dual-pointer circular RAM with commit/rewind (write port, registered 1-cycle read port, full flag, frames_avail counter). The FSM and padding stay in the top level.

Test Plan:
- Permit 20-word frame (words 32'h0000_0001..32'h0000_0014), tready=1 -> 20 txd beats in order, tlast on 32'h0000_0014, tvalid low 3 cycles, o_frames_sent=1.
- Permit 5-word frame -> 5 data words, then 10 words of 32'h0, tlast on beat 15.
- Deny 20-word frame, then permit a 16-word frame -> only the 16-word frame appears; o_frames_dropped=1, o_frames_sent=1.
- Permit 16-word frame with i_txd_tready toggling every cycle -> tdata/tvalid held stable during stalls; all 16 words delivered once, in order.
- FIFO_DEPTH=16, tready=0, permit 10-word frame then a 10-word frame -> second frame overflows and is dropped (o_frames_dropped=1); after tready=1, only the first frame is sent.
- Assert rst for 2 cycles mid-SEND on word 7 -> all outputs 0 within the reset cycle, no tlast; o_pkt_tready=0 until 1 cycle after release; the next permitted frame transmits normally.
